// File: rtl/i2s_tx_frame_sched.sv
// I2S transmit frame scheduler: generates lrclk framing in the bclk domain, fetches
// samples from the TX FIFO, stages them and strobes them into the output shifter.
module i2s_tx_frame_sched #(
  parameter int unsigned SAMPLE_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH   = 32,
  parameter logic        I2S_MODE     = 1'b0
) (
  input  logic                    bclk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [SAMPLE_WIDTH-1:0] fifo_rdata,
  output logic                    lrclk,
  output logic                    load,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    underflow,
  output logic [7:0]              underflow_cnt,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(SLOT_WIDTH);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_FETCH = CNT_W'(SLOT_WIDTH - 4);
  localparam logic [CNT_W-1:0] CNT_CAPT  = CNT_W'(SLOT_WIDTH - 3);
  // lrclk leads the slot MSB by one bclk in I2S mode
  localparam logic [CNT_W-1:0] CNT_LRCLK = (I2S_MODE == 1'b1) ? CNT_W'(SLOT_WIDTH - 2)
                                                              : CNT_W'(SLOT_WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        slot_cnt_q, slot_cnt_d;
  logic                    channel_q, channel_d;
  logic                    lrclk_q, lrclk_d;
  logic                    fifo_rd_en_q, fifo_rd_en_d;
  logic                    load_q, load_d;
  logic [SAMPLE_WIDTH-1:0] sample_out_q, sample_out_d;
  logic [SAMPLE_WIDTH-1:0] staged_q, staged_d;
  logic                    underflow_q, underflow_d;
  logic [7:0]              underflow_cnt_q, underflow_cnt_d;
  logic                    busy_q, busy_d;
  logic                    mute_q, mute_d;
  logic                    stop_q, stop_d;
  logic                    fetch_c;
  logic                    suppress_c;

  // Next-state and output decode; registered outputs are decoded from next-state
  // values so each strobe is visible in the slot_cnt cycle it belongs to.
  always_comb begin
    state_d         = state_q;
    slot_cnt_d      = slot_cnt_q;
    channel_d       = channel_q;
    lrclk_d         = lrclk_q;
    fifo_rd_en_d    = 1'b0;
    load_d          = 1'b0;
    sample_out_d    = sample_out_q;
    staged_d        = staged_q;
    underflow_d     = 1'b0;
    underflow_cnt_d = underflow_cnt_q;
    mute_d          = mute_q;
    stop_d          = stop_q;
    fetch_c         = 1'b0;
    suppress_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d    = ST_PRIME;
          slot_cnt_d = CNT_FETCH;
          channel_d  = 1'b1;
        end
      end
      ST_PRIME: begin
        if (slot_cnt_q == CNT_LAST) begin
          state_d    = ST_RUN;
          slot_cnt_d = '0;
          channel_d  = 1'b0;
        end else begin
          slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (slot_cnt_q == CNT_LAST) begin
          slot_cnt_d = '0;
          if (channel_q && stop_q) begin
            state_d   = ST_IDLE;
            channel_d = 1'b1;
          end else begin
            channel_d = ~channel_q;
          end
        end else begin
          slot_cnt_d = slot_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        slot_cnt_d = '0;
        channel_d  = 1'b1;
      end
    endcase

    // A pending stop keeps lrclk high so the return to IDLE makes no extra edge
    if (state_q == ST_IDLE) begin
      lrclk_d = 1'b1;
    end else if (slot_cnt_q == CNT_LRCLK) begin
      lrclk_d = (state_q == ST_PRIME) ? 1'b0 : (stop_q | ~channel_q);
    end

    fetch_c    = (state_d != ST_IDLE) && (slot_cnt_d == CNT_FETCH);
    suppress_c = fetch_c && (state_d == ST_RUN) && channel_d && !enable;

    if (fetch_c) begin
      stop_d = suppress_c;
      mute_d = suppress_c | fifo_empty;
      if (!suppress_c) begin
        if (!fifo_empty) begin
          fifo_rd_en_d = 1'b1;
        end else begin
          underflow_d = 1'b1;
          if (underflow_cnt_q != 8'hFF) begin
            underflow_cnt_d = underflow_cnt_q + 8'd1;
          end
        end
      end
    end

    // FIFO data is valid the cycle after the read strobe
    if ((state_q != ST_IDLE) && (slot_cnt_q == CNT_CAPT)) begin
      staged_d = mute_q ? '0 : fifo_rdata;
    end

    if ((state_d != ST_IDLE) && (slot_cnt_d == CNT_LAST) && !stop_d) begin
      load_d       = 1'b1;
      sample_out_d = staged_q;
    end

    if (state_d == ST_IDLE) begin
      stop_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge bclk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      slot_cnt_q      <= '0;
      channel_q       <= 1'b1;
      lrclk_q         <= 1'b1;
      fifo_rd_en_q    <= 1'b0;
      load_q          <= 1'b0;
      sample_out_q    <= '0;
      staged_q        <= '0;
      underflow_q     <= 1'b0;
      underflow_cnt_q <= '0;
      busy_q          <= 1'b0;
      mute_q          <= 1'b0;
      stop_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      slot_cnt_q      <= slot_cnt_d;
      channel_q       <= channel_d;
      lrclk_q         <= lrclk_d;
      fifo_rd_en_q    <= fifo_rd_en_d;
      load_q          <= load_d;
      sample_out_q    <= sample_out_d;
      staged_q        <= staged_d;
      underflow_q     <= underflow_d;
      underflow_cnt_q <= underflow_cnt_d;
      busy_q          <= busy_d;
      mute_q          <= mute_d;
      stop_q          <= stop_d;
    end
  end

  assign fifo_rd_en    = fifo_rd_en_q;
  assign lrclk         = lrclk_q;
  assign load          = load_q;
  assign sample_out    = sample_out_q;
  assign underflow     = underflow_q;
  assign underflow_cnt = underflow_cnt_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_i2s_tx_frame_sched.sv
// Bench for i2s_tx_frame_sched: a left-justified and an I2S instance share one FIFO model
// and are checked against hand-computed cycle vectors plus stop/reset/saturation sequences.
module tb_i2s_tx_frame_sched;

  localparam int unsigned SW = 24;

  logic          bclk;
  logic          resetn;
  logic          enable;
  logic          fifo_empty;
  logic [SW-1:0] fifo_rdata;

  logic          fifo_rd_en, lrclk, load, underflow, busy;
  logic [SW-1:0] sample_out;
  logic [7:0]    underflow_cnt;

  logic          fifo_rd_en_i, lrclk_i, load_i, underflow_i, busy_i;
  logic [SW-1:0] sample_out_i;
  logic [7:0]    underflow_cnt_i;

  i2s_tx_frame_sched #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(32), .I2S_MODE(1'b0)) u_dut (
    .bclk(bclk), .resetn(resetn), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .lrclk(lrclk), .load(load),
    .sample_out(sample_out), .underflow(underflow), .underflow_cnt(underflow_cnt),
    .busy(busy)
  );

  i2s_tx_frame_sched #(.SAMPLE_WIDTH(SW), .SLOT_WIDTH(32), .I2S_MODE(1'b1)) u_dut_i2s (
    .bclk(bclk), .resetn(resetn), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en_i), .fifo_rdata(fifo_rdata), .lrclk(lrclk_i), .load(load_i),
    .sample_out(sample_out_i), .underflow(underflow_i), .underflow_cnt(underflow_cnt_i),
    .busy(busy_i)
  );

  initial begin
    bclk = 1'b0;
    forever #5 bclk = ~bclk;
  end

  typedef struct {
    int            cyc;
    logic          push;
    logic [SW-1:0] push_val;
    logic          lr;
    logic          lri;
    logic          rd;
    logic          ld;
    logic [SW-1:0] samp;
    logic          uf;
    logic [7:0]    ufc;
    logic          busy;
  } vec_t;

  vec_t          vecs[$];
  logic [SW-1:0] fifo_q[$];
  logic          force_empty;
  int            total;
  int            bad;
  int            cyc;

  function automatic vec_t mk(input int c, input logic p, input logic [SW-1:0] pv,
                              input logic lr, input logic lri, input logic rd, input logic ld,
                              input logic [SW-1:0] s, input logic uf, input logic [7:0] ufc,
                              input logic b);
    vec_t v;
    v.cyc = c; v.push = p; v.push_val = pv; v.lr = lr; v.lri = lri; v.rd = rd; v.ld = ld;
    v.samp = s; v.uf = uf; v.ufc = ufc; v.busy = b;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = force_empty || (fifo_q.size() == 0);
  endtask

  // One bclk: FIFO presents popped data the cycle after a read strobe
  task automatic tick();
    logic rd;
    rd = fifo_rd_en;
    @(posedge bclk);
    #1;
    cyc++;
    if (rd) begin
      if (fifo_q.size() > 0) fifo_rdata = fifo_q.pop_front();
      else fifo_rdata = '0;
    end
    upd_empty();
  endtask

  task automatic check_vec(input vec_t v);
    chk("lrclk",         32'(lrclk),           32'(v.lr));
    chk("lrclk_i2s",     32'(lrclk_i),         32'(v.lri));
    chk("rd_en",         32'(fifo_rd_en),      32'(v.rd));
    chk("rd_en_i2s",     32'(fifo_rd_en_i),    32'(v.rd));
    chk("load",          32'(load),            32'(v.ld));
    chk("load_i2s",      32'(load_i),          32'(v.ld));
    chk("sample",        32'(sample_out),      32'(v.samp));
    chk("sample_i2s",    32'(sample_out_i),    32'(v.samp));
    chk("underflow",     32'(underflow),       32'(v.uf));
    chk("underflow_cnt", 32'(underflow_cnt),   32'(v.ufc));
    chk("uf_cnt_i2s",    32'(underflow_cnt_i), 32'(v.ufc));
    chk("busy",          32'(busy),            32'(v.busy));
    chk("busy_i2s",      32'(busy_i),          32'(v.busy));
  endtask

  initial begin
    int n_rd, n_ld, n_uf, n_lo, n_bad;
    total = 0; bad = 0; cyc = 0;
    resetn = 1'b0; enable = 1'b0; force_empty = 1'b0; fifo_rdata = '0;
    fifo_q.push_back(24'h123456);
    fifo_q.push_back(24'hABCDEF);
    fifo_q.push_back(24'h5A5A5A);
    upd_empty();

    //                cyc push pval        lr lri rd ld samp        uf ufc  busy
    vecs.push_back(mk(0,   0, 24'h0,       1, 1,  0, 0, 24'h000000, 0, 8'd0, 0));
    vecs.push_back(mk(1,   0, 24'h0,       1, 1,  1, 0, 24'h000000, 0, 8'd0, 1));
    vecs.push_back(mk(2,   0, 24'h0,       1, 1,  0, 0, 24'h000000, 0, 8'd0, 1));
    vecs.push_back(mk(3,   0, 24'h0,       1, 1,  0, 0, 24'h000000, 0, 8'd0, 1));
    vecs.push_back(mk(4,   0, 24'h0,       1, 0,  0, 1, 24'h123456, 0, 8'd0, 1));
    vecs.push_back(mk(5,   0, 24'h0,       0, 0,  0, 0, 24'h123456, 0, 8'd0, 1));
    vecs.push_back(mk(33,  0, 24'h0,       0, 0,  1, 0, 24'h123456, 0, 8'd0, 1));
    vecs.push_back(mk(35,  0, 24'h0,       0, 0,  0, 0, 24'h123456, 0, 8'd0, 1));
    vecs.push_back(mk(36,  0, 24'h0,       0, 1,  0, 1, 24'hABCDEF, 0, 8'd0, 1));
    vecs.push_back(mk(37,  0, 24'h0,       1, 1,  0, 0, 24'hABCDEF, 0, 8'd0, 1));
    vecs.push_back(mk(65,  0, 24'h0,       1, 1,  1, 0, 24'hABCDEF, 0, 8'd0, 1));
    vecs.push_back(mk(67,  0, 24'h0,       1, 1,  0, 0, 24'hABCDEF, 0, 8'd0, 1));
    vecs.push_back(mk(68,  0, 24'h0,       1, 0,  0, 1, 24'h5A5A5A, 0, 8'd0, 1));
    vecs.push_back(mk(69,  0, 24'h0,       0, 0,  0, 0, 24'h5A5A5A, 0, 8'd0, 1));
    vecs.push_back(mk(97,  1, 24'h0F0F0F,  0, 0,  0, 0, 24'h5A5A5A, 1, 8'd1, 1));
    vecs.push_back(mk(98,  0, 24'h0,       0, 0,  0, 0, 24'h5A5A5A, 0, 8'd1, 1));
    vecs.push_back(mk(100, 0, 24'h0,       0, 1,  0, 1, 24'h000000, 0, 8'd1, 1));
    vecs.push_back(mk(101, 0, 24'h0,       1, 1,  0, 0, 24'h000000, 0, 8'd1, 1));
    vecs.push_back(mk(129, 0, 24'h0,       1, 1,  1, 0, 24'h000000, 0, 8'd1, 1));
    vecs.push_back(mk(132, 0, 24'h0,       1, 0,  0, 1, 24'h0F0F0F, 0, 8'd1, 1));
    vecs.push_back(mk(133, 0, 24'h0,       0, 0,  0, 0, 24'h0F0F0F, 0, 8'd1, 1));

    repeat (3) @(posedge bclk);
    #1;
    enable = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      while (cyc < vecs[i].cyc) begin
        resetn = 1'b1;
        tick();
      end
      check_vec(vecs[i]);
      if (vecs[i].push) begin
        fifo_q.push_back(vecs[i].push_val);
        upd_empty();
      end
    end

    // Disable mid left slot: the right-channel sample still goes out, then the frame ends
    fifo_q.push_back(24'h111111);
    fifo_q.push_back(24'h222222);
    upd_empty();
    while (cyc < 140) tick();
    enable = 1'b0;
    while (cyc < 161) tick();
    chk("stop_fetch_rd", 32'(fifo_rd_en), 32'd1);
    while (cyc < 164) tick();
    chk("stop_load", 32'(load), 32'd1);
    chk("stop_sample", 32'(sample_out), 32'h111111);
    n_rd = 0; n_ld = 0; n_uf = 0; n_lo = 0;
    while (cyc < 205) begin
      tick();
      if (fifo_rd_en || fifo_rd_en_i) n_rd++;
      if (load || load_i) n_ld++;
      if (underflow || underflow_i) n_uf++;
      if (!lrclk || !lrclk_i) n_lo++;
      if (cyc == 196) begin
        chk("stop_busy_last", 32'(busy), 32'd1);
      end
      if (cyc == 197) begin
        chk("stop_idle_busy", 32'(busy), 32'd0);
        chk("stop_idle_busy_i2s", 32'(busy_i), 32'd0);
        chk("stop_idle_lrclk", 32'(lrclk), 32'd1);
      end
    end
    chk("stop_no_rd", 32'(n_rd), 32'd0);
    chk("stop_no_load", 32'(n_ld), 32'd0);
    chk("stop_no_uf", 32'(n_uf), 32'd0);
    chk("stop_lrclk_high", 32'(n_lo), 32'd0);

    // Re-prime, then reset mid left slot at slot_cnt=10
    enable = 1'b1;
    tick();
    chk("reprime_rd", 32'(fifo_rd_en), 32'd1);
    chk("reprime_busy", 32'(busy), 32'd1);
    while (cyc < 209) tick();
    chk("reprime_load", 32'(load), 32'd1);
    chk("reprime_sample", 32'(sample_out), 32'h222222);
    while (cyc < 220) tick();
    resetn = 1'b0;
    #1;
    chk("rst_lrclk", 32'(lrclk), 32'd1);
    chk("rst_lrclk_i2s", 32'(lrclk_i), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sample", 32'(sample_out), 32'd0);
    chk("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_rd", 32'(fifo_rd_en), 32'd0);
    enable = 1'b0;
    fifo_q.push_back(24'h333333);
    upd_empty();
    tick();
    resetn = 1'b1;
    n_bad = 0;
    repeat (40) begin
      tick();
      if (fifo_rd_en || load || busy || load_i) n_bad++;
    end
    chk("rst_idle_quiet", 32'(n_bad), 32'd0);
    enable = 1'b1;
    tick();
    chk("rst_reprime_rd", 32'(fifo_rd_en), 32'd1);
    repeat (3) tick();
    chk("rst_reprime_load", 32'(load), 32'd1);
    chk("rst_reprime_sample", 32'(sample_out), 32'h333333);

    // Starved FIFO: underflow_cnt saturates at 255
    force_empty = 1'b1;
    upd_empty();
    n_uf = 0; n_rd = 0;
    for (int k = 0; (k < 300 * 32 + 200) && (n_uf < 300); k++) begin
      tick();
      if (fifo_rd_en) n_rd++;
      if (underflow) begin
        n_uf++;
        if (n_uf == 1) chk("sat_cnt_1", 32'(underflow_cnt), 32'd1);
        if (n_uf == 254) chk("sat_cnt_254", 32'(underflow_cnt), 32'd254);
      end
    end
    chk("sat_pulses", 32'(n_uf), 32'd300);
    chk("sat_cnt_final", 32'(underflow_cnt), 32'd255);
    chk("sat_cnt_final_i2s", 32'(underflow_cnt_i), 32'd255);
    chk("sat_no_rd", 32'(n_rd), 32'd0);
    chk("sat_muted_sample", 32'(sample_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_frame_sched.md
Name: i2s_tx_frame_sched

Overview:
- Transmit-side counterpart of the I2S receive write controller.
- Runs in the bclk domain and generates the word-select (lrclk) frame timing.
- Schedules reads from the TX sample FIFO and hands each sample to the output shift register with a one-cycle load strobe.
- Handles FIFO underflow by muting the slot, and makes enable/disable transitions glitch-free on frame boundaries.

Parameters:
- SAMPLE_WIDTH, 24: bits per sample, equal to the FIFO data width.
- SLOT_WIDTH, 32: bclk cycles per channel slot. Legal range is SAMPLE_WIDTH to 64, and never below 8.
- I2S_MODE, 1'b0: 0 = left-justified, where lrclk changes with the slot MSB. 1 = I2S, where lrclk changes one bclk before the slot MSB.

Ports:
- bclk, input, 1: bit clock, the only clock.
- resetn, input, 1: asynchronous active-low reset.
- enable, input, 1: transmit enable. Sampled every bclk.
- fifo_empty, input, 1: TX FIFO empty flag.
- fifo_rd_en, output, 1: one-cycle FIFO read strobe. FIFO data is valid on the following cycle.
- fifo_rdata, input, SAMPLE_WIDTH: FIFO read data.
- lrclk, output, 1: word select. 0 = left, 1 = right. Registered.
- load, output, 1: one-cycle strobe. The shift register captures sample_out on the next bclk edge.
- sample_out, output, SAMPLE_WIDTH: staged sample for the next slot.
- underflow, output, 1: one-cycle pulse when a fetch finds the FIFO empty.
- underflow_cnt, output, 8: saturating underflow count. Cleared only by reset.
- busy, output, 1: high in PRIME and RUN.

Behaviour:
- Reset (asynchronous, active-low), all values:
  - state=IDLE, slot_cnt=0, channel=1
  - lrclk=1, fifo_rd_en=0, load=0, sample_out=0
  - underflow=0, underflow_cnt=0, busy=0
  - Reset asserted mid-frame aborts immediately. No partial load is issued after release.
- State IDLE:
  - lrclk held at 1, no reads.
  - If enable=1: go to PRIME, with slot_cnt<=SLOT_WIDTH-4 and channel<=1.
- State PRIME:
  - slot_cnt increments each cycle. Fetch and load behave exactly as in RUN, with lrclk held at 1.
  - At slot_cnt==SLOT_WIDTH-1: go to RUN, with slot_cnt<=0 and channel<=0. This is the first left slot and produces a falling lrclk edge.
- State RUN:
  - slot_cnt counts 0..SLOT_WIDTH-1 and wraps to 0. channel toggles on the wrap.
  - On the wrap out of a right slot with enable=0: go to IDLE, slot_cnt<=0, channel<=1.
  - Disable therefore always completes the current left+right frame.
- Fetch cycle (slot_cnt==SLOT_WIDTH-4):
  - The fetch is suppressed when channel==1, enable==0 and state==RUN; the frame will end.
  - Otherwise:
    - If !fifo_empty, assert fifo_rd_en for 1 cycle.
    - If fifo_empty, pulse underflow for 1 cycle, increment underflow_cnt (saturating at 255), and set a mute flag.
- Capture (slot_cnt==SLOT_WIDTH-3): the staging register takes fifo_rdata if a read was issued, otherwise 0.
- Load (slot_cnt==SLOT_WIDTH-1):
  - Assert load for 1 cycle, with sample_out = staged value.
  - sample_out holds its value between loads.
  - No load is issued in a suppressed (final) fetch slot.
- lrclk timing, registered:
  - I2S_MODE=0: lrclk<=next channel at the slot_cnt==SLOT_WIDTH-1 edge, so it changes together with slot_cnt=0.
  - I2S_MODE=1: update at the SLOT_WIDTH-2 edge, i.e. one bclk earlier.
  - Returning to IDLE leaves lrclk=1 with no extra edge.
- enable toggling:
  - enable toggling in PRIME does not abort priming.
  - Re-asserting enable before the frame end cancels the pending stop, provided it arrives before the right-slot fetch cycle.
- busy = (state != IDLE).

Test Plan:
- Reset, enable=1, FIFO holds 0x123456, 0xABCDEF -> first load at PRIME end with sample_out=0x123456. lrclk falls at the RUN start. Second load 32 bclks later with 0xABCDEF, lrclk rising with slot_cnt=0.
- I2S_MODE=1, same stimulus -> every lrclk edge occurs exactly 1 bclk before the matching left-justified position. Load timing unchanged.
- FIFO empty during the right-slot fetch -> underflow pulse, underflow_cnt=1, no fifo_rd_en, and load carries sample_out=0. The next fetch with data resumes normally.
- Hold fifo_empty=1 for 300 fetches -> underflow_cnt saturates at 255.
- Deassert enable mid left slot -> right-slot fetch and load still occur, then no further fifo_rd_en. IDLE with lrclk=1 and busy=0 at the right-slot wrap.
- Assert resetn=0 for 1 cycle mid-slot at slot_cnt=10 -> all outputs return to reset values asynchronously. No load or fifo_rd_en until re-prime after enable.
